// File: rtl/adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// adc_spi_sampler : multi-channel SPI sampler for AD7476A-class ADCs sharing
// one SCLK/CS_N. Optional lead-bit check: ADC_SPI_SAMPLER_LEAD_CHECK_EN.
// Revision 1.0
// ============================================================================
module adc_spi_sampler #(
  parameter int CLK_DIV        = 5,
  parameter int NUM_CHANNELS   = 2,
  parameter int FRAME_BITS     = 16,
  parameter int LEAD_BITS      = 4,
  parameter int DATA_BITS      = 12,
  parameter int T_CS_CYCLES    = 1,
  parameter int T_QUIET_CYCLES = 9,
  parameter int PERIOD_W       = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              request_i,
  input  logic                              continuous_i,
  input  logic [PERIOD_W-1:0]               period_i,
  output logic                              busy_o,
  output logic [NUM_CHANNELS*DATA_BITS-1:0] data_o,
  output logic                              data_valid_o,
  output logic                              frame_error_o,
  output logic                              sclk_o,
  output logic                              cs_n_o,
  input  logic [NUM_CHANNELS-1:0]           sdata_i
);

  localparam int LOW_CYCLES = CLK_DIV / 2;
  localparam int CNT_MAX_A  = (T_CS_CYCLES > T_QUIET_CYCLES) ? T_CS_CYCLES : T_QUIET_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_A > CLK_DIV) ? CNT_MAX_A : CLK_DIV;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int DATA_W     = NUM_CHANNELS * DATA_BITS;

  localparam logic [CNT_W-1:0] C_CS_LAST    = CNT_W'(T_CS_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_QUIET_LAST = CNT_W'(T_QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_RISE_PHASE = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LOW        = CNT_W'(LOW_CYCLES);
  localparam logic [BIT_W-1:0] C_BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] C_DATA_FIRST = BIT_W'(LEAD_BITS);
  localparam logic [BIT_W-1:0] C_DATA_END   = BIT_W'(LEAD_BITS + DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_QUIET    = 3'd3,
    S_STROBE   = 3'd4
  } state_t;

  state_t                                 state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [BIT_W-1:0]                       bit_q, bit_d;
  logic [PERIOD_W-1:0]                    period_cnt_q, period_cnt_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0]                      data_q, data_d;
  logic                                   cs_n_q, cs_n_d;
  logic                                   sclk_q, sclk_d;
  logic                                   valid_q, valid_d;
  logic                                   busy_q, busy_d;
  logic                                   start;
  logic                                   rise;

  assign start = request_i | (continuous_i & (period_cnt_q == '0));
  // Last low-phase cycle of an SCLK period: the next edge raises SCLK and samples.
  assign rise  = (state_q == S_SHIFT) && (cnt_q == C_RISE_PHASE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    period_cnt_d = (period_cnt_q != '0) ? period_cnt_q - 1'b1 : '0;

    unique case (state_q)
      S_IDLE, S_STROBE: begin
        if (start) begin
          state_d      = S_CS_SETUP;
          cnt_d        = '0;
          period_cnt_d = (period_i != '0) ? period_i - 1'b1 : '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CS_SETUP: begin
        if (cnt_q == C_CS_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == C_DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == C_BIT_LAST) state_d = S_QUIET;
          else                     bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (rise && (bit_q >= C_DATA_FIRST) && (bit_q < C_DATA_END)) begin
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            shreg_d[k] = (shreg_q[k] << 1) | DATA_BITS'(sdata_i[k]);
          end
        end
      end
      S_QUIET: begin
        if (cnt_q == C_QUIET_LAST) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up with it.
    cs_n_d  = !((state_d == S_CS_SETUP) || (state_d == S_SHIFT));
    sclk_d  = !((state_d == S_SHIFT) && (cnt_d < C_LOW));
    valid_d = (state_d == S_STROBE);
    busy_d  = (state_d != S_IDLE);
    data_d  = (state_d == S_STROBE) ? shreg_q : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      period_cnt_q <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b1;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      period_cnt_q <= period_cnt_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      cs_n_q       <= cs_n_d;
      sclk_q       <= sclk_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ADC_SPI_SAMPLER_LEAD_CHECK_EN
  logic lead_seen_q, lead_seen_d;
  logic frame_error_q, frame_error_d;

  always_comb begin
    lead_seen_d   = lead_seen_q;
    frame_error_d = frame_error_q;
    if (((state_q == S_IDLE) || (state_q == S_STROBE)) && start) begin
      lead_seen_d = 1'b0;
    end else if (rise && (bit_q < C_DATA_FIRST)) begin
      lead_seen_d = lead_seen_q | (|sdata_i);
    end
    if (state_d == S_STROBE) frame_error_d = lead_seen_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lead_seen_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      lead_seen_q   <= lead_seen_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign frame_error_o = frame_error_q;
`else
  assign frame_error_o = 1'b0;
`endif

  assign cs_n_o       = cs_n_q;
  assign sclk_o       = sclk_q;
  assign data_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign data_o       = data_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
`default_nettype none
// tb_adc_spi_sampler : ADC behavioural model plus frame scoreboard for adc_spi_sampler.
module tb_adc_spi_sampler;

  localparam int CLK_DIV        = 5;
  localparam int NUM_CHANNELS   = 2;
  localparam int FRAME_BITS     = 16;
  localparam int LEAD_BITS      = 4;
  localparam int DATA_BITS      = 12;
  localparam int T_CS_CYCLES    = 1;
  localparam int T_QUIET_CYCLES = 9;
  localparam int PERIOD_W       = 16;
  localparam int DATA_W         = NUM_CHANNELS * DATA_BITS;
  // Cycle number of the strobe when the request is sampled at cycle 0.
  localparam int LAT = 1 + T_CS_CYCLES + FRAME_BITS * CLK_DIV + T_QUIET_CYCLES;
`ifdef ADC_SPI_SAMPLER_LEAD_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic                    clk_i        = 1'b0;
  logic                    rst_i        = 1'b1;
  logic                    request_i    = 1'b0;
  logic                    continuous_i = 1'b0;
  logic [PERIOD_W-1:0]     period_i     = '0;
  logic [NUM_CHANNELS-1:0] sdata_i      = '0;
  logic                    busy_o, data_valid_o, frame_error_o, sclk_o, cs_n_o;
  logic [DATA_W-1:0]       data_o;

  adc_spi_sampler #(
    .CLK_DIV(CLK_DIV), .NUM_CHANNELS(NUM_CHANNELS), .FRAME_BITS(FRAME_BITS),
    .LEAD_BITS(LEAD_BITS), .DATA_BITS(DATA_BITS), .T_CS_CYCLES(T_CS_CYCLES),
    .T_QUIET_CYCLES(T_QUIET_CYCLES), .PERIOD_W(PERIOD_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .request_i(request_i), .continuous_i(continuous_i),
    .period_i(period_i), .busy_o(busy_o), .data_o(data_o), .data_valid_o(data_valid_o),
    .frame_error_o(frame_error_o), .sclk_o(sclk_o), .cs_n_o(cs_n_o), .sdata_i(sdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  int total = 0, passed = 0, failed = 0;
  int strobe_cnt = 0, fall_cnt = 0;
  bit prev_cs = 1'b0;
  bit fixed_en = 1'b0, lead_err_en = 1'b0;
  logic [FRAME_BITS-1:0] fixed_word [NUM_CHANNELS];
  logic [FRAME_BITS-1:0] word       [NUM_CHANNELS];

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;
  exp_t exp_q[$];
  int   cs_fall_q[$];
  int   strobe_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame start: pick the words each ADC will send and predict the strobe contents.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && prev_cs && !cs_n_o) begin
      cs_fall_q.push_back(cyc);
      fall_cnt = 0;
      e.data = '0;
      e.err  = 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        if (fixed_en) begin
          word[k] = fixed_word[k];
        end else begin
          word[k] = FRAME_BITS'($urandom);
          if (!(lead_err_en && ($urandom_range(0, 1) == 1)))
            for (int s = 0; s < LEAD_BITS; s++) word[k][FRAME_BITS-1-s] = 1'b0;
        end
        for (int s = 0; s < DATA_BITS; s++)
          e.data[k*DATA_BITS + DATA_BITS-1-s] = word[k][FRAME_BITS-1-LEAD_BITS-s];
        if (CHECK_EN)
          for (int s = 0; s < LEAD_BITS; s++) e.err = e.err | word[k][FRAME_BITS-1-s];
      end
      exp_q.push_back(e);
    end
    prev_cs = cs_n_o;
  end

  // ADC model: sample n is presented after the n-th SCLK fall of the frame.
  always @(negedge sclk_o) begin
    if (!cs_n_o && !rst_i) begin
      for (int k = 0; k < NUM_CHANNELS; k++)
        sdata_i[k] = (fall_cnt < FRAME_BITS) ? word[k][FRAME_BITS-1-fall_cnt] : 1'b0;
      fall_cnt++;
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && data_valid_o) begin
      strobe_cnt++;
      strobe_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(data_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 64'(data_o), 64'(e.data));
        check("sb_frame_error", 64'(frame_error_o), 64'(e.err));
        check("sb_sclk_falls", 64'(fall_cnt), 64'(FRAME_BITS));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk_i);
  endtask

  task automatic pulse_request(output int c0);
    @(negedge clk_i);
    request_i = 1'b1;
    c0 = cyc + 1;
    @(negedge clk_i);
    request_i = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (data_valid_o === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({tag, "_strobe_timeout"}, 64'(data_valid_o), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (busy_o === 1'b0) break;
    end
    check({tag, "_idle"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int c0, at, n0, f0;
    fixed_word[0] = 16'h0BA5;
    fixed_word[1] = 16'h0123;

    // Reset
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_cs_n", 64'(cs_n_o), 64'd1);
    check("rst_sclk", 64'(sclk_o), 64'd1);
    check("rst_valid", 64'(data_valid_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_frame_error", 64'(frame_error_o), 64'd0);
    rst_i = 1'b0;
    wait_cycles(3);

    // Single shot with the reference words
    fixed_en = 1'b1;
    pulse_request(c0);
    wait_strobe("single", 200, at);
    check("single_strobe_cycle", 64'(at), 64'(c0 + LAT - 1));
    check("single_data", 64'(data_o), 64'h123BA5);
    check("single_cs_fall_cycle", 64'(cs_fall_q[$]), 64'(c0));
    check("single_falls", 64'(fall_cnt), 64'd16);
    @(negedge clk_i);
    check("single_busy_after", 64'(busy_o), 64'd0);

    // Randomized single shots, lead bits sometimes dirty
    fixed_en    = 1'b0;
    lead_err_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cycles($urandom_range(1, 20));
      pulse_request(c0);
      wait_strobe("rand", 200, at);
      check("rand_strobe_cycle", 64'(at), 64'(c0 + LAT - 1));
      wait_idle("rand", 10);
    end

    // Request during a frame is dropped
    lead_err_en = 1'b0;
    n0 = strobe_cnt;
    f0 = cs_fall_q.size();
    pulse_request(c0);
    wait_until(c0 + 39);
    request_i = 1'b1;
    @(negedge clk_i);
    request_i = 1'b0;
    wait_strobe("ignored", 200, at);
    wait_idle("ignored", 10);
    wait_cycles(100);
    check("ignored_strobes", 64'(strobe_cnt), 64'(n0 + 1));
    check("ignored_cs_falls", 64'(cs_fall_q.size()), 64'(f0 + 1));

    // Periodic, 200-cycle period
    cs_fall_q.delete();
    strobe_q.delete();
    @(negedge clk_i);
    period_i     = 16'd200;
    continuous_i = 1'b1;
    for (int i = 0; i < 1000 && cs_fall_q.size() < 4; i++) @(negedge clk_i);
    for (int i = 1; i < 4; i++)
      check("period200_cs_spacing", 64'(cs_fall_q[i] - cs_fall_q[i-1]), 64'd200);
    for (int i = 1; i < 3; i++)
      check("period200_strobe_spacing", 64'(strobe_q[i] - strobe_q[i-1]), 64'd200);
    continuous_i = 1'b0;
    n0 = strobe_cnt;
    wait_idle("period200_stop", 200);
    wait_cycles(250);
    check("period200_last_frame", 64'(strobe_cnt), 64'(n0 + 1));

    // Periodic, period shorter than a frame: back-to-back
    cs_fall_q.delete();
    strobe_q.delete();
    @(negedge clk_i);
    period_i     = 16'd10;
    continuous_i = 1'b1;
    for (int i = 0; i < 400 && cs_fall_q.size() < 3; i++) @(negedge clk_i);
    for (int i = 1; i < 3; i++)
      check("period10_cs_spacing", 64'(cs_fall_q[i] - cs_fall_q[i-1]), 64'(LAT));
    check("period10_strobe_spacing", 64'(strobe_q[1] - strobe_q[0]), 64'(LAT));
    continuous_i = 1'b0;
    wait_idle("period10_stop", 200);
    wait_cycles(5);

    // Reset in the middle of a frame
    n0 = strobe_cnt;
    pulse_request(c0);
    wait_until(c0 + 29);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_cs_n", 64'(cs_n_o), 64'd1);
    check("midrst_sclk", 64'(sclk_o), 64'd1);
    check("midrst_data", 64'(data_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    exp_q.delete();
    wait_cycles(150);
    check("midrst_no_strobe", 64'(strobe_cnt), 64'(n0));

    // Lead-bit check: ch1 drives 1 on sample 2, then a clean frame
    fixed_en      = 1'b1;
    fixed_word[1] = 16'h2123;
    pulse_request(c0);
    wait_strobe("lead_dirty", 200, at);
    check("lead_dirty_error", 64'(frame_error_o), 64'(CHECK_EN));
    check("lead_dirty_data", 64'(data_o), 64'h123BA5);
    wait_idle("lead_dirty", 10);
    fixed_word[1] = 16'h0123;
    pulse_request(c0);
    wait_strobe("lead_clean", 200, at);
    check("lead_clean_error", 64'(frame_error_o), 64'd0);
    wait_idle("lead_clean", 10);
    wait_cycles(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
